// File: rtl/control_unit_pkg.sv
// ctrl_pkg: shared state, opcode, ALUop and immSel encodings for the control unit and datapath.
package ctrl_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WRBK   = 3'd4,
    S_TRAP   = 3'd7
  } state_e;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT
  } alu_op_e;
  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_NONE} imm_sel_e;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  function automatic imm_sel_e imm_sel(input logic [6:0] op);
    return op == OP_STORE ? IMM_S : op == OP_BRANCH ? IMM_B :
           (op == OP_I || op == OP_LOAD) ? IMM_I : IMM_NONE;
  endfunction
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: control unit <-> datapath signals; CTRL_PERF_COUNTERS_EN adds the counter outputs.
interface control_unit_if;
  logic [31:0] instr;
  logic [1:0]  status;
  logic [1:0]  immSel;
  logic [1:0]  regRW;
  logic        ALUsrc;
  logic [2:0]  ALUop;
  logic        MRW;
  logic        PCsrc;
  logic        WB;
  logic        pc_we;
  logic [2:0]  state;
  logic        illegal;
`ifdef CTRL_PERF_COUNTERS_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
`endif
  modport master (
    input  instr, status,
    output immSel, regRW, ALUsrc, ALUop, MRW, PCsrc, WB, pc_we, state, illegal
`ifdef CTRL_PERF_COUNTERS_EN
    , output cycle_cnt, instret_cnt
`endif
  );
  modport slave (
    output instr, status,
    input  immSel, regRW, ALUsrc, ALUop, MRW, PCsrc, WB, pc_we, state, illegal
`ifdef CTRL_PERF_COUNTERS_EN
    , input cycle_cnt, instret_cnt
`endif
  );
endinterface

// File: rtl/control_unit_alu_decode.sv
// alu_decode: maps opcode/funct3/funct7 to ALUop, a supported-opcode flag and a full legality flag.
module alu_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [2:0] alu_op_o,
  output logic       op_ok_o,
  output logic       legal_o
);
  logic is_r, is_i, is_ls, is_b, arith_ok, f7_ok, shift;
  alu_op_e arith_op;
  assign is_r  = opcode_i == OP_R;
  assign is_i  = opcode_i == OP_I;
  assign is_ls = opcode_i == OP_LOAD || opcode_i == OP_STORE;
  assign is_b  = opcode_i == OP_BRANCH;
  assign shift = funct3_i == 3'b001 || funct3_i == 3'b101;
  always_comb begin
    arith_op = ALU_ADD;
    arith_ok = 1'b1;
    case (funct3_i)
      3'b000:  arith_op = (is_r && funct7_i[5]) ? ALU_SUB : ALU_ADD;
      3'b111:  arith_op = ALU_AND;
      3'b110:  arith_op = ALU_OR;
      3'b100:  arith_op = ALU_XOR;
      3'b001:  arith_op = ALU_SLL;
      3'b101:  arith_op = ALU_SRL;
      3'b010:  arith_op = ALU_SLT;
      default: arith_ok = 1'b0;
    endcase
  end
  // R-type allows funct7 only as 0 or SUB; I-type shift immediates carry funct7 too
  assign f7_ok = is_r ? (funct7_i == 7'b0 || (funct7_i == 7'b0100000 && funct3_i == 3'b000))
                      : (!shift || funct7_i == 7'b0);
  assign alu_op_o = is_ls ? ALU_ADD : is_b ? ALU_SUB : arith_op;
  assign op_ok_o  = is_r || is_i || is_ls || is_b;
  assign legal_o  = (is_r || is_i) ? (arith_ok && f7_ok) :
                    is_b ? (funct3_i[2:1] != 2'b01 && funct3_i[2:1] != 2'b11) : is_ls;
endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/DECODE/EXEC/MEM/WRBK sequencer driving the datapath controls.
// CTRL_PERF_COUNTERS_EN adds cycle and retired-instruction counters.
module control_unit
  import ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  control_unit_if.master bus
);
  state_e state_q, state_d;
  logic [16:0] ir_q, ir_d;
  logic [6:0] opcode;
  logic [2:0] alu_op;
  logic op_ok, legal, is_load, is_store, is_b, use_imm, taken;
  assign opcode   = ir_q[6:0];
  assign ir_d     = state_q == S_FETCH ? {bus.instr[31:25], bus.instr[14:12], bus.instr[6:0]} : ir_q;
  assign is_load  = opcode == OP_LOAD;
  assign is_store = opcode == OP_STORE;
  assign is_b     = opcode == OP_BRANCH;
  assign use_imm  = opcode == OP_I || is_load || is_store;
  // funct3[2] picks negative vs zero flag, funct3[0] inverts it
  assign taken    = ir_q[9] ? (bus.status[1] ^ ir_q[7]) : (bus.status[0] ^ ir_q[7]);
  alu_decode u_dec (
    .opcode_i (opcode),
    .funct3_i (ir_q[9:7]),
    .funct7_i (ir_q[16:10]),
    .alu_op_o (alu_op),
    .op_ok_o  (op_ok),
    .legal_o  (legal)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    bus.immSel = 2'b00;
    bus.regRW  = 2'b00;
    bus.ALUsrc = 1'b0;
    bus.ALUop  = 3'b000;
    bus.MRW    = 1'b0;
    bus.PCsrc  = 1'b0;
    bus.WB     = 1'b0;
    bus.pc_we  = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        bus.regRW  = 2'b01;
        bus.immSel = imm_sel(opcode);
        state_d    = op_ok ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        bus.regRW  = 2'b01;
        bus.immSel = imm_sel(opcode);
        bus.ALUsrc = use_imm;
        bus.ALUop  = alu_op;
        bus.pc_we  = legal && is_b;
        bus.PCsrc  = legal && is_b && taken;
        state_d    = !legal ? S_TRAP : is_b ? S_FETCH : (is_load || is_store) ? S_MEM : S_WRBK;
      end
      S_MEM: begin
        bus.immSel = imm_sel(opcode);
        bus.ALUsrc = use_imm;
        bus.ALUop  = alu_op;
        bus.MRW    = is_store;
        bus.pc_we  = is_store;
        bus.WB     = is_load;
        state_d    = is_store ? S_FETCH : S_WRBK;
      end
      S_WRBK: begin
        bus.immSel = imm_sel(opcode);
        bus.ALUsrc = use_imm;
        bus.ALUop  = alu_op;
        bus.regRW  = 2'b10;
        bus.pc_we  = 1'b1;
        bus.WB     = is_load;
        state_d    = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase
  end
  assign bus.state   = state_q;
  assign bus.illegal = state_q == S_TRAP;
`ifdef CTRL_PERF_COUNTERS_EN
  logic [31:0] cycle_q, instret_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_q + 32'd1;
      instret_q <= instret_q + {31'd0, bus.pc_we};
    end
  end
  assign bus.cycle_cnt   = cycle_q;
  assign bus.instret_cnt = instret_q;
`endif
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench; per-cycle expected control records are queued per instruction and popped each cycle.
module tb_control_unit;
  typedef struct packed {
    logic [2:0] st;
    logic [1:0] imm;
    logic [1:0] rw;
    logic       src;
    logic [2:0] op;
    logic       mrw, pcs, wb, pcwe, ill;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  control_unit_if bus();
  control_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic push(input logic [2:0] st, input logic [1:0] imm, input logic [1:0] rw,
                      input logic src, input logic [2:0] op, input logic mrw, input logic pcs,
                      input logic wb, input logic pcwe, input logic ill);
    q.push_back('{st, imm, rw, src, op, mrw, pcs, wb, pcwe, ill});
  endtask
  task automatic push_fetch();
    push(3'd0, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic push_trap(input int n);
    repeat (n) push(3'd7, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic step();
    exp_t x;
    if (q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
    else begin
      x = q.pop_front();
      check("state", {29'd0, bus.state}, {29'd0, x.st});
      check("immSel", {30'd0, bus.immSel}, {30'd0, x.imm});
      check("regRW", {30'd0, bus.regRW}, {30'd0, x.rw});
      check("ALUsrc", {31'd0, bus.ALUsrc}, {31'd0, x.src});
      check("ALUop", {29'd0, bus.ALUop}, {29'd0, x.op});
      check("MRW", {31'd0, bus.MRW}, {31'd0, x.mrw});
      check("PCsrc", {31'd0, bus.PCsrc}, {31'd0, x.pcs});
      check("WB", {31'd0, bus.WB}, {31'd0, x.wb});
      check("pc_we", {31'd0, bus.pc_we}, {31'd0, x.pcwe});
      check("illegal", {31'd0, bus.illegal}, {31'd0, x.ill});
    end
    @(negedge clk);
  endtask
  // instr is scrambled after the FETCH edge to confirm it is only sampled there
  task automatic run(input logic [31:0] ins, input logic [1:0] st);
    int n;
    n = q.size();
    bus.instr = ins;
    bus.status = st;
    step();
    bus.instr = $urandom;
    repeat (n - 1) step();
  endtask
  task automatic add_recs(input logic [2:0] op);
    push_fetch();
    push(3'd1, 2'b11, 2'b01, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3'd2, 2'b11, 2'b01, 1'b0, op, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3'd4, 2'b11, 2'b10, 1'b0, op, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic branch(input logic [31:0] ins, input logic [1:0] st, input logic tk);
    push_fetch();
    push(3'd1, 2'b10, 2'b01, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3'd2, 2'b10, 2'b01, 1'b0, 3'd1, 1'b0, tk, 1'b0, 1'b1, 1'b0);
    run(ins, st);
  endtask
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_state", {29'd0, bus.state}, 32'd0);
    check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    check("rst_strobes", {28'd0, bus.pc_we, bus.MRW, bus.regRW}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.instr = 32'h0;
    bus.status = 2'b00;
    repeat (2) @(negedge clk);
    check("reset_state", {29'd0, bus.state}, 32'd0);
    check("reset_outs", {22'd0, bus.immSel, bus.regRW, bus.ALUsrc, bus.ALUop, bus.MRW, bus.PCsrc, bus.WB},
          32'd0);
    rst = 1'b0;
    repeat (3) begin
      add_recs(3'd0);
      run(32'h002081B3, 2'b11);
    end
`ifdef CTRL_PERF_COUNTERS_EN
    check("instret_cnt", bus.instret_cnt, 32'd3);
    check("cycle_cnt", bus.cycle_cnt, 32'd12);
`endif
    add_recs(3'd1);
    run(32'h402081B3, 2'b00);
    push_fetch();
    push(3'd1, 2'b00, 2'b01, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3'd2, 2'b00, 2'b01, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3'd4, 2'b00, 2'b10, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run(32'h00506093, 2'b00);
    push_fetch();
    push(3'd1, 2'b00, 2'b01, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3'd2, 2'b00, 2'b01, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3'd3, 2'b00, 2'b00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(3'd4, 2'b00, 2'b10, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run(32'h0080A283, 2'b00);
    push_fetch();
    push(3'd1, 2'b01, 2'b01, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3'd2, 2'b01, 2'b01, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3'd3, 2'b01, 2'b00, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run(32'h0050A223, 2'b00);
    branch(32'h00208463, 2'b01, 1'b1);
    branch(32'h00208463, 2'b00, 1'b0);
    branch(32'h00209463, 2'b00, 1'b1);
    branch(32'h0020C463, 2'b10, 1'b1);
    branch(32'h0020D463, 2'b10, 1'b0);
    push_fetch();
    push(3'd1, 2'b01, 2'b01, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3'd2, 2'b01, 2'b01, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(32'h0050A223, 2'b00);
    async_reset();
    push_fetch();
    push(3'd1, 2'b10, 2'b01, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3'd2, 2'b10, 2'b01, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_trap(2);
    run(32'h0020A463, 2'b01);
    async_reset();
    push_fetch();
    push(3'd1, 2'b11, 2'b01, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_trap(20);
    run(32'h0000007F, 2'b11);
    async_reset();
    add_recs(3'd0);
    run(32'h002081B3, 2'b00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
